// File: rtl/gmii_frame_checker.sv
// Receive-side GMII frame delineator: preamble/SFD validation, CRC-32 residue, length and idle-gap measurement.
// Latency: the record is registered and frame_done pulses the cycle after the first rx_dv=0 sample that ends a frame.
// Backpressure: none; every frame produces exactly one record, in arrival order.
module gmii_frame_checker #(
   parameter int unsigned MIN_FRAME_OCTETS = 64,
   parameter int unsigned MAX_FRAME_OCTETS = 1522
) (
   input  logic        aclk,
   input  logic        arst,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   output logic        frame_done,
   output logic [15:0] frame_octets,
   output logic [15:0] frame_idle,
   output logic        frame_crc_ok,
   output logic        frame_err
);

   localparam logic [7:0]  PRE_BYTE    = 8'h55;
   localparam logic [7:0]  SFD_BYTE    = 8'hD5;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [16:0] MIN_LEN     = 17'(MIN_FRAME_OCTETS);
   localparam logic [16:0] MAX_LEN     = 17'(MAX_FRAME_OCTETS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRE,
      S_DATA,
      S_DISC
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] crc_q;
   logic [15:0] oct_cnt;
   logic [15:0] idle_cnt;
   logic [15:0] idle_lat;
   logic        err_q;

   logic        frame_start;
   logic        sfd_acc;
   logic        set_err;
   logic        emit;
   logic        emit_data;
   logic        er_hit;
   logic        len_bad;

   // Reflected CRC-32 update for one byte, LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   assign er_hit  = gmii_rx_dv && gmii_rx_er && (state != S_IDLE);
   assign len_bad = ({1'b0, oct_cnt} < MIN_LEN) || ({1'b0, oct_cnt} > MAX_LEN);

   // Frame delineation state register.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      sfd_acc     = 1'b0;
      set_err     = 1'b0;
      emit        = 1'b0;
      emit_data   = 1'b0;
      case (state)
         S_IDLE: begin
            if (gmii_rx_dv) begin
               frame_start = 1'b1;
               if (gmii_rxd == PRE_BYTE) begin
                  state_nxt = S_PRE;
               end else if (gmii_rxd == SFD_BYTE) begin
                  state_nxt = S_DATA;
                  sfd_acc   = 1'b1;
               end else begin
                  state_nxt = S_DISC;
                  set_err   = 1'b1;
               end
            end
         end
         S_PRE: begin
            if (!gmii_rx_dv) begin
               state_nxt = S_IDLE;
               emit      = 1'b1;
            end else if (gmii_rxd == SFD_BYTE) begin
               state_nxt = S_DATA;
               sfd_acc   = 1'b1;
            end else if (gmii_rxd != PRE_BYTE) begin
               state_nxt = S_DISC;
               set_err   = 1'b1;
            end
         end
         S_DATA: begin
            if (!gmii_rx_dv) begin
               state_nxt = S_IDLE;
               emit      = 1'b1;
               emit_data = 1'b1;
            end
         end
         S_DISC: begin
            if (!gmii_rx_dv) begin
               state_nxt = S_IDLE;
               emit      = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Sticky frame error: cleared at frame start, set by rx_er or a preamble fault.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst)                err_q <= 1'b0;
      else if (frame_start)    err_q <= set_err;
      else if (set_err || er_hit) err_q <= 1'b1;
   end

   // CRC register: seeded on SFD, updated by every DATA byte including the FCS.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst)                                 crc_q <= CRC_INIT;
      else if (sfd_acc)                         crc_q <= CRC_INIT;
      else if (state == S_DATA && gmii_rx_dv)   crc_q <= crc_byte(crc_q, gmii_rxd);
   end

   // Saturating octet counter for the DATA phase.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst)                oct_cnt <= 16'd0;
      else if (sfd_acc)        oct_cnt <= 16'd0;
      else if (state == S_DATA && gmii_rx_dv && oct_cnt != 16'hFFFF)
                               oct_cnt <= oct_cnt + 16'd1;
   end

   // Idle-gap counter; the frame-ending rx_dv=0 cycle is the first idle cycle of the next gap.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         idle_cnt <= 16'd0;
         idle_lat <= 16'd0;
      end else if (state == S_IDLE) begin
         if (gmii_rx_dv) begin
            idle_lat <= idle_cnt;
            idle_cnt <= 16'd0;
         end else if (idle_cnt != 16'hFFFF) begin
            idle_cnt <= idle_cnt + 16'd1;
         end
      end else if (!gmii_rx_dv) begin
         idle_cnt <= 16'd1;
      end
   end

   // Registered frame record, loaded on the emit edge and held until the next one.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         frame_done   <= 1'b0;
         frame_octets <= 16'd0;
         frame_idle   <= 16'd0;
         frame_crc_ok <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         frame_done <= emit;
         if (emit) begin
            frame_octets <= emit_data ? oct_cnt : 16'd0;
            frame_idle   <= idle_lat;
            frame_crc_ok <= emit_data && (crc_q == CRC_RESIDUE);
            frame_err    <= !emit_data || err_q || len_bad;
         end
      end
   end

endmodule

// File: tb/tb_gmii_frame_checker.sv
// Bench for gmii_frame_checker: table of frame vectors plus reset, false-carrier and back-to-back sequences.
// Inputs change on the falling edge; the record is sampled 1 ns after the emit rising edge.
// Frame check sequences are generated here with a standard CRC-32 over the payload.
module tb_gmii_frame_checker;

   logic        aclk = 1'b0;
   logic        arst;
   logic [7:0]  gmii_rxd;
   logic        gmii_rx_dv;
   logic        gmii_rx_er;
   logic        frame_done;
   logic [15:0] frame_octets;
   logic [15:0] frame_idle;
   logic        frame_crc_ok;
   logic        frame_err;

   gmii_frame_checker dut (
      .aclk         (aclk),
      .arst         (arst),
      .gmii_rxd     (gmii_rxd),
      .gmii_rx_dv   (gmii_rx_dv),
      .gmii_rx_er   (gmii_rx_er),
      .frame_done   (frame_done),
      .frame_octets (frame_octets),
      .frame_idle   (frame_idle),
      .frame_crc_ok (frame_crc_ok),
      .frame_err    (frame_err)
   );

   always #5 aclk = ~aclk;

   localparam int K_GOOD  = 0;  // 7 x 0x55, SFD, payload, FCS
   localparam int K_NOPRE = 1;  // SFD only, payload, FCS
   localparam int K_BADPRE = 2; // 0x55, 0x55, 0xAA, 50 bytes
   localparam int K_DROP  = 3;  // 3 x 0x55 then rx_dv falls

   typedef struct {
      int   kind;
      int   gap;
      int   fc;
      int   pay;
      bit   corrupt;
      int   er_at;
      bit   chk_idle;
      int   e_oct;
      int   e_idle;
      bit   e_crc;
      bit   e_err;
   } vec_t;

   int          n_chk = 0;
   int          n_err = 0;
   int          pending = 0;
   int          exp_pulses = 0;
   int          pulse_cnt = 0;
   int          oct_sum = 0;
   logic [7:0]  fb[$];
   logic        fe[$];
   vec_t        tbl[12];

   // Independent record counter, sampled well after each rising edge.
   always @(posedge aclk) begin
      #2;
      if (frame_done === 1'b1) begin
         pulse_cnt = pulse_cnt + 1;
         oct_sum   = oct_sum + int'(frame_octets);
      end
   end

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic dv, input logic er, input logic [7:0] d);
      @(negedge aclk);
      gmii_rx_dv = dv;
      gmii_rx_er = er;
      gmii_rxd   = d;
   endtask

   task automatic build(input int kind, input int pay, input bit corrupt, input int er_at);
      logic [31:0] c;
      logic [31:0] fcs;
      int          base;
      fb.delete();
      fe.delete();
      c = 32'hFFFF_FFFF;
      if (kind == K_GOOD) begin
         for (int i = 0; i < 7; i++) begin fb.push_back(8'h55); fe.push_back(1'b0); end
      end
      if (kind == K_GOOD || kind == K_NOPRE) begin
         fb.push_back(8'hD5); fe.push_back(1'b0);
         base = fb.size();
         for (int i = 0; i < pay; i++) begin
            fb.push_back(8'((i + 1) & 255));
            fe.push_back(1'b0);
            c = crc_upd(c, 8'((i + 1) & 255));
         end
         fcs = ~c;
         fb.push_back(fcs[7:0]);   fe.push_back(1'b0);
         fb.push_back(fcs[15:8]);  fe.push_back(1'b0);
         fb.push_back(fcs[23:16]); fe.push_back(1'b0);
         fb.push_back(corrupt ? (fcs[31:24] ^ 8'h01) : fcs[31:24]); fe.push_back(1'b0);
         if (er_at > 0) fe[base + er_at - 1] = 1'b1;
      end else if (kind == K_BADPRE) begin
         fb.push_back(8'h55); fb.push_back(8'h55); fb.push_back(8'hAA);
         for (int i = 0; i < 3; i++) fe.push_back(1'b0);
         for (int i = 0; i < 50; i++) begin fb.push_back(8'(i + 16)); fe.push_back(1'b0); end
      end else begin
         for (int i = 0; i < 3; i++) begin fb.push_back(8'h55); fe.push_back(1'b0); end
      end
   endtask

   task automatic check_rec(input string nm, input int e_oct, input bit chk_idle, input int e_idle,
                            input bit e_crc, input bit e_err);
      chk({nm, ".done"},    32'(frame_done), 32'd1);
      chk({nm, ".records"}, 32'(pulse_cnt), 32'(exp_pulses));
      exp_pulses++;
      chk({nm, ".octets"},  32'(frame_octets), 32'(e_oct));
      chk({nm, ".crc_ok"},  32'(frame_crc_ok), 32'(e_crc));
      chk({nm, ".err"},     32'(frame_err), 32'(e_err));
      if (chk_idle) chk({nm, ".idle"}, 32'(frame_idle), 32'(e_idle));
   endtask

   task automatic run_vec(input string nm, input vec_t v);
      build(v.kind, v.pay, v.corrupt, v.er_at);
      for (int i = 0; i < v.gap - pending; i++) drive(1'b0, (i < v.fc), 8'h00);
      for (int i = 0; i < fb.size(); i++) drive(1'b1, fe[i], fb[i]);
      drive(1'b0, 1'b0, 8'h00);
      pending = 1;
      @(posedge aclk); #1;
      check_rec(nm, v.e_oct, v.chk_idle, v.e_idle, v.e_crc, v.e_err);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".done"},   32'(frame_done), 32'd0);
      chk({nm, ".octets"}, 32'(frame_octets), 32'd0);
      chk({nm, ".idle"},   32'(frame_idle), 32'd0);
      chk({nm, ".crc_ok"}, 32'(frame_crc_ok), 32'd0);
      chk({nm, ".err"},    32'(frame_err), 32'd0);
   endtask

   initial begin
      int   p0;
      int   s0;
      vec_t good;

      //           kind     gap fc  pay  corr er  chkI oct   idle crc err
      tbl[0]  = '{K_GOOD,   12, 0,  60,  0,   -1, 1,   64,   12,  1,  0};
      tbl[1]  = '{K_GOOD,   12, 0,  60,  1,   -1, 1,   64,   12,  0,  0};
      tbl[2]  = '{K_GOOD,   12, 0,  60,  0,   10, 1,   64,   12,  1,  1};
      tbl[3]  = '{K_GOOD,   12, 0,  36,  0,   -1, 1,   40,   12,  1,  1};
      tbl[4]  = '{K_GOOD,   1,  0,  60,  0,   -1, 1,   64,   1,   1,  0};
      tbl[5]  = '{K_GOOD,   12, 5,  60,  0,   -1, 1,   64,   12,  1,  0};
      tbl[6]  = '{K_NOPRE,  5,  0,  60,  0,   -1, 1,   64,   5,   1,  0};
      tbl[7]  = '{K_GOOD,   4,  0,  59,  0,   -1, 1,   63,   4,   1,  1};
      tbl[8]  = '{K_GOOD,   4,  0,  1518, 0,  -1, 1,   1522, 4,   1,  0};
      tbl[9]  = '{K_GOOD,   4,  0,  1519, 0,  -1, 1,   1523, 4,   1,  1};
      tbl[10] = '{K_BADPRE, 12, 0,  0,   0,   -1, 1,   0,    12,  0,  1};
      tbl[11] = '{K_DROP,   12, 0,  0,   0,   -1, 0,   0,    0,   0,  1};
      good    = '{K_GOOD,   12, 0,  60,  0,   -1, 1,   64,   12,  1,  0};

      arst       = 1'b1;
      gmii_rx_dv = 1'b0;
      gmii_rx_er = 1'b0;
      gmii_rxd   = 8'h00;
      repeat (3) @(negedge aclk);
      chk_zero("reset");
      @(negedge aclk);
      arst    = 1'b0;
      pending = 1;

      for (int v = 0; v < 12; v++) run_vec($sformatf("vec%0d", v), tbl[v]);

      // Reset asserted during data byte 30, released while rx_dv is still high.
      build(K_GOOD, 60, 1'b0, -1);
      for (int i = 0; i < 12 - pending; i++) drive(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < fb.size(); i++) begin
         @(negedge aclk);
         gmii_rx_dv = 1'b1;
         gmii_rx_er = 1'b0;
         gmii_rxd   = fb[i];
         if (i == 8 + 29) begin
            arst = 1'b1;
            #1;
            chk_zero("midreset");
         end
         if (i == 8 + 31) arst = 1'b0;
      end
      drive(1'b0, 1'b0, 8'h00);
      pending = 1;
      @(posedge aclk); #1;
      check_rec("postreset", 0, 1'b1, 0, 1'b0, 1'b1);

      // Back-to-back good frames with a 12-cycle gap.
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      pending = 3;
      p0 = pulse_cnt;
      s0 = oct_sum;
      for (int f = 0; f < 100; f++) run_vec($sformatf("b2b%0d", f), good);
      repeat (3) drive(1'b0, 1'b0, 8'h00);
      chk("b2b.count", 32'(pulse_cnt - p0), 32'd100);
      chk("b2b.octet_sum", 32'(oct_sum - s0), 32'd6400);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/gmii_frame_checker.md
# gmii_frame_checker

Receive-side GMII frame parser that sits directly upstream of `traffic_analyzer_gmii`, on the output of the analyzer-side `gmii_mux`. It delineates frames on the 8-bit GMII receive stream, validates the preamble/SFD, checks CRC-32 and length, and measures the idle gap. For each frame it produces a one-cycle summary record, from which the analyzer updates its PKTS, OCTETS, OCTETS_IDLE, BAD_CRC_PKTS and BAD_CRC_OCTETS counters.

## Interface
- `MIN_FRAME_OCTETS`, default 64: minimum legal length in octets, counted after the SFD and including the FCS.
- `MAX_FRAME_OCTETS`, default 1522: maximum legal length, counted the same way.
- `aclk  in  1`: clock. Everything is sampled on the rising edge.
- `arst  in  1`: reset. One clock; reset is asynchronous and active-high.
- `gmii_rxd  in  8`: receive data.
- `gmii_rx_dv  in  1`: receive data valid.
- `gmii_rx_er  in  1`: receive error.
- `frame_done  out  1`: single-cycle pulse that presents one frame record.
- `frame_octets  out  16`: octets after the SFD, FCS included; saturates at 0xFFFF.
- `frame_idle  out  16`: count of `rx_dv=0` cycles before this frame; saturates at 0xFFFF.
- `frame_crc_ok  out  1`: 1 when the CRC residue is correct.
- `frame_err  out  1`: set by a preamble/SFD fault, `rx_er` during the frame, a runt, or an oversize frame.

## Operation
- CRC: reflected CRC-32.
  - Polynomial 0xEDB88320, processed LSB-first, one byte per cycle.
  - The register is set to 0xFFFFFFFF on SFD acceptance.
  - Every DATA byte updates the register, FCS bytes included.
  - `crc_ok` = (register == 0xDEBB20E3) at frame end.
- Counters:
  - The octet counter clears on SFD acceptance and increments per DATA byte.
  - The idle counter increments on every cycle with `rx_dv=0` in IDLE.
  - On the first `rx_dv=1` cycle, the idle count is latched into an internal register and the idle counter clears.
  - All counters saturate and never wrap.
- A sticky `err` bit clears at frame start. It is set by `rx_er=1` on any cycle with `rx_dv=1` while in PREAMBLE, DATA or DISCARD.
- State machine:
  - IDLE:
    - `rx_dv=1` and `rxd=0x55` → PREAMBLE.
    - `rx_dv=1` and `rxd=0xD5` → DATA (zero-length preamble accepted).
    - `rx_dv=1` and any other `rxd` → DISCARD with `err` set.
    - `rx_er` while `rx_dv=0` is ignored (false carrier and extension are not counted).
  - PREAMBLE:
    - `rxd=0x55` → stay.
    - `rxd=0xD5` → DATA.
    - Any other byte → DISCARD with `err` set.
    - `rx_dv=0` → emit a record with `err=1`, `octets=0`, `crc_ok=0`; go to IDLE.
  - DATA:
    - `rx_dv=1` → accumulate.
    - `rx_dv=0` → emit a record and go to IDLE. This cycle also counts as the first idle cycle of the next gap.
    - `err` is additionally set if `octets < MIN_FRAME_OCTETS` or `octets > MAX_FRAME_OCTETS`.
  - DISCARD: wait for `rx_dv=0`, then emit a record with `err=1`, `crc_ok=0`, the octet count as 0, and the latched idle count; go to IDLE.
- Record outputs are registered. They load on the emit edge and hold until the next emit.

## Timing
- Reset: every output is 0, state = IDLE, all counters are 0, the CRC register is 0xFFFFFFFF.
  - A frame in progress when reset releases is seen by IDLE as a non-preamble byte → DISCARD → reported with `err=1`.
  - Reset asserted mid-frame drops the frame with no record.
- Latency: `frame_done` is high for exactly one cycle. It is the cycle after the first cycle in which `rx_dv=0` is sampled at the end of a frame.
- There is no backpressure: back-to-back frames separated by a single idle cycle each produce a record, in order.
- A minimum-gap frame (1 idle cycle) reports `frame_idle=1`.
- The first frame after reset reports the number of idle cycles since reset release.
- Octet count at 0xFFFF stays at 0xFFFF. The oversize error is still raised, and the CRC is still computed.

## Test plan
- Good minimum frame:
  - Stimulus: 12 idle cycles, then 7×0x55 and 0xD5, then bytes 0x01..0x3C, then FCS 0x34,0x4C,0xA0,0x62.
  - Response: `frame_done` pulse with `octets=64`, `idle=12`, `crc_ok=1`, `err=0`.
- Corrupt FCS:
  - Stimulus: the same frame with the last byte 0x63.
  - Response: `octets=64`, `crc_ok=0`, `err=0`.
- `rx_er` and runt:
  - Stimulus: the same frame with `rx_er=1` on data byte 10.
  - Response: `err=1`, `crc_ok=1`.
  - Stimulus: a 40-octet frame with valid FCS.
  - Response: `octets=40`, `err=1`.
- Preamble faults:
  - Stimulus: 0x55,0x55,0xAA, then 50 bytes.
  - Response: DISCARD; record `octets=0`, `err=1`.
  - Stimulus: `rx_dv` dropping after 3×0x55.
  - Response: `octets=0`, `err=1`.
- Back-to-back frames:
  - Stimulus: 100 good 64-octet frames with a 12-cycle gap.
  - Response: exactly 100 pulses, each with `idle=12` and `crc_ok=1`. Summed octets = 6400.
- Reset mid-frame and false carrier:
  - Stimulus: assert `arst` during byte 30, release while `rx_dv` is still high.
  - Response: all outputs 0 during reset; after release, one record with `err=1`.
  - Stimulus: `rx_er=1` with `rx_dv=0` for 5 cycles.
  - Response: no record; `idle` keeps counting.
